// File: rtl/ahb_gpio_master_arb_pkg.sv
// Shared FSM state type and AHB/GPIO constants for the GPIO bus master.
package ahb_ctrl_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} ahb_st_t;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

  localparam logic [31:0] GPIO_DATA_OFS = 32'h0000_0000;
  localparam logic [31:0] GPIO_DIR_OFS  = 32'h0000_0004;

endpackage

// File: rtl/ahb_gpio_master_arb_if.sv
// Command-side and AHB-side signal bundle for the GPIO bus master.
interface ahb_gpio_master_arb_if #(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]    REQ;
  logic [NREQ-1:0]    WR;
  logic [NREQ*32-1:0] ADDR;
  logic [NREQ*32-1:0] WDATA;
  logic [NREQ-1:0]    GNT;
  logic [NREQ-1:0]    DONE;
  logic               ERR;
  logic [31:0]        RDATA;
  logic               HSEL;
  logic [31:0]        HADDR;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic [31:0]        HWDATA;
  logic               HREADY;
  logic               HREADYOUT;
  logic [31:0]        HRDATA;

  modport master (
    input  REQ, WR, ADDR, WDATA, HREADYOUT, HRDATA,
    output GNT, DONE, ERR, RDATA, HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY
  );

  modport slave (
    output REQ, WR, ADDR, WDATA, HREADYOUT, HRDATA,
    input  GNT, DONE, ERR, RDATA, HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY
  );

endinterface

// File: rtl/ahb_gpio_master_arb_rr.sv
// Combinational round-robin picker: first requester after ptr (wrapping) wins.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // k = N revisits ptr itself, so a lone requester equal to ptr still wins
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/ahb_gpio_master_arb.sv
// Round-robin arbiter plus single-transfer AHB-Lite master in front of one GPIO slave.
module ahb_gpio_master_arb
  import ahb_ctrl_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input logic                   HCLK,
  input logic                   HRESET,
  ahb_gpio_master_arb_if.master bus
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WAIT_MAX  = CW'(TIMEOUT);

  ahb_st_t         state_reg, state_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [CW-1:0]   wait_reg, wait_next;
  logic            cmd_wr_reg, cmd_wr_next;
  logic [31:0]     cmd_wdata_reg, cmd_wdata_next;
  logic            hsel_reg, hsel_next;
  logic [1:0]      htrans_reg, htrans_next;
  logic            hwrite_reg, hwrite_next;
  logic [31:0]     haddr_reg, haddr_next;
  logic [31:0]     hwdata_reg, hwdata_next;
  logic [31:0]     rdata_reg, rdata_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [NREQ-1:0] done_reg, done_next;
  logic            err_reg, err_next;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic [31:0]     addr_arr  [NREQ];
  logic [31:0]     wdata_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.ADDR[gi*32 +: 32];
    assign wdata_arr[gi] = bus.WDATA[gi*32 +: 32];
  end

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req (bus.REQ),
    .ptr (ptr_reg),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= PW'(NREQ - 1);
      wait_reg      <= '0;
      cmd_wr_reg    <= 1'b0;
      cmd_wdata_reg <= '0;
      hsel_reg      <= 1'b0;
      htrans_reg    <= HTRANS_IDLE;
      hwrite_reg    <= 1'b0;
      haddr_reg     <= '0;
      hwdata_reg    <= '0;
      rdata_reg     <= '0;
      gnt_reg       <= '0;
      done_reg      <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      wait_reg      <= wait_next;
      cmd_wr_reg    <= cmd_wr_next;
      cmd_wdata_reg <= cmd_wdata_next;
      hsel_reg      <= hsel_next;
      htrans_reg    <= htrans_next;
      hwrite_reg    <= hwrite_next;
      haddr_reg     <= haddr_next;
      hwdata_reg    <= hwdata_next;
      rdata_reg     <= rdata_next;
      gnt_reg       <= gnt_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  // ptr_reg doubles as the index of the requester owning the current transfer
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    wait_next      = wait_reg;
    cmd_wr_next    = cmd_wr_reg;
    cmd_wdata_next = cmd_wdata_reg;
    hsel_next      = hsel_reg;
    htrans_next    = htrans_reg;
    hwrite_next    = hwrite_reg;
    haddr_next     = haddr_reg;
    hwdata_next    = hwdata_reg;
    rdata_next     = rdata_reg;
    gnt_next       = '0;
    done_next      = '0;
    err_next       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (|bus.REQ) begin
          state_next     = ST_ADDR;
          ptr_next       = arb_idx;
          gnt_next       = arb_gnt;
          cmd_wr_next    = bus.WR[arb_idx];
          cmd_wdata_next = wdata_arr[arb_idx];
          haddr_next     = addr_arr[arb_idx];
          hwrite_next    = bus.WR[arb_idx];
          hsel_next      = 1'b1;
          htrans_next    = HTRANS_NONSEQ;
        end
      end

      ST_ADDR: begin
        if (bus.HREADYOUT) begin
          state_next  = ST_DATA;
          hsel_next   = 1'b0;
          htrans_next = HTRANS_IDLE;
          hwrite_next = 1'b0;
          wait_next   = '0;
          if (cmd_wr_reg) begin
            hwdata_next = cmd_wdata_reg;
          end
        end
      end

      ST_DATA: begin
        if (bus.HREADYOUT) begin
          state_next          = ST_IDLE;
          done_next[ptr_reg]  = 1'b1;
          if (!cmd_wr_reg) begin
            rdata_next = bus.HRDATA;
          end
        end else if (wait_reg == WAIT_LAST) begin
          state_next          = ST_IDLE;
          done_next[ptr_reg]  = 1'b1;
          err_next            = 1'b1;
        end else if (wait_reg != WAIT_MAX) begin
          wait_next = wait_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.GNT    = gnt_reg;
  assign bus.DONE   = done_reg;
  assign bus.ERR    = err_reg;
  assign bus.RDATA  = rdata_reg;
  assign bus.HSEL   = hsel_reg;
  assign bus.HADDR  = haddr_reg;
  assign bus.HTRANS = htrans_reg;
  assign bus.HWRITE = hwrite_reg;
  assign bus.HWDATA = hwdata_reg;
  assign bus.HREADY = bus.HREADYOUT;

endmodule

// File: tb/tb_ahb_gpio_master_arb.sv
// Scoreboard bench for ahb_gpio_master_arb with a behavioural GPIO slave.
module tb_ahb_gpio_master_arb;

  typedef struct {
    int          req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  int gnt_cycle = 0;

  exp_t exp_q[$];

  int          stall_cfg;
  logic        stuck;
  logic [31:0] slave_rdata;
  logic        dp;
  logic        dp_pending;
  int          wait_left;
  logic [31:0] last_rdata;

  ahb_gpio_master_arb_if #(.NREQ(2)) bus ();

  ahb_gpio_master_arb #(.NREQ(2), .TIMEOUT(16)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic expect_xfer(input int r, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] rd,
                             input logic err, input int lat);
    exp_t e;
    e.req = r; e.wr = wr; e.addr = a; e.wdata = d; e.rdata = rd; e.err = err; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Raises REQ at the current negedge and drops it on the negedge GNT is seen.
  task automatic requester(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    bus.REQ[r]          = 1'b1;
    bus.WR[r]           = wr;
    bus.ADDR[r*32 +: 32]  = a;
    bus.WDATA[r*32 +: 32] = d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.GNT[r]) begin
        got = 1'b1;
        break;
      end
    end
    bus.REQ[r] = 1'b0;
    check("gnt_wait", got, 1'b1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_hsel",   bus.HSEL,   0);
    check("rst_htrans", bus.HTRANS, 0);
    check("rst_hwrite", bus.HWRITE, 0);
    check("rst_haddr",  bus.HADDR,  0);
    check("rst_hwdata", bus.HWDATA, 0);
    check("rst_gnt",    bus.GNT,    0);
    check("rst_done",   bus.DONE,   0);
    check("rst_err",    bus.ERR,    0);
    check("rst_rdata",  bus.RDATA,  0);
  endtask

  // Slave model and scoreboard monitor, both sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      dp            = 1'b0;
      dp_pending    = 1'b0;
      wait_left     = 0;
      last_rdata    = '0;
      bus.HREADYOUT = 1'b1;
      bus.HRDATA    = '0;
    end else begin
      if (dp) check("hready", bus.HREADY, bus.HREADYOUT);
      if (dp_pending) begin
        dp         = 1'b1;
        dp_pending = 1'b0;
        wait_left  = stall_cfg;
        check("dp_bus_idle", {bus.HSEL, bus.HTRANS}, 0);
        if (exp_q.size() > 0 && exp_q[0].wr) check("hwdata", bus.HWDATA, exp_q[0].wdata);
      end
      if (dp) begin
        if (stuck || wait_left > 0) begin
          bus.HREADYOUT = 1'b0;
          if (!stuck) wait_left--;
        end else begin
          bus.HREADYOUT = 1'b1;
          dp = 1'b0;
        end
      end else begin
        bus.HREADYOUT = 1'b1;
      end
      bus.HRDATA = slave_rdata;
      if (bus.HSEL && bus.HTRANS == 2'b10 && bus.HREADYOUT) dp_pending = 1'b1;

      if (bus.GNT != 0) begin
        if (exp_q.size() == 0) check("gnt_spurious", bus.GNT, 0);
        else begin
          check("gnt_order", bus.GNT, 64'(1) << exp_q[0].req);
          gnt_cycle = cycle;
        end
      end
      if (bus.HSEL && exp_q.size() > 0) begin
        check("htrans", bus.HTRANS, 2'b10);
        check("haddr",  bus.HADDR,  exp_q[0].addr);
        check("hwrite", bus.HWRITE, exp_q[0].wr);
      end
      if (bus.DONE != 0) begin
        if (exp_q.size() == 0) check("done_spurious", bus.DONE, 0);
        else begin
          e = exp_q.pop_front();
          check("done", bus.DONE, 64'(1) << e.req);
          check("err",  bus.ERR,  e.err);
          if (!e.wr && !e.err) last_rdata = e.rdata;
          check("rdata", bus.RDATA, last_rdata);
          check("latency", cycle - gnt_cycle, e.lat);
          $display("[TB] xfer req%0d %s addr=0x%08h err=%0d rdata=0x%08h lat=%0d",
                   e.req, e.wr ? "WR" : "RD", e.addr, bus.ERR, bus.RDATA, cycle - gnt_cycle);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.REQ     = '0;
    bus.WR      = '0;
    bus.ADDR    = '0;
    bus.WDATA   = '0;
    stall_cfg   = 0;
    stuck       = 1'b0;
    slave_rdata = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // Idle bus with no requests
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_bus", {bus.HSEL, bus.HTRANS, bus.GNT, bus.DONE}, 0);
    end

    // Single write, zero wait states
    expect_xfer(0, 1'b1, 32'h5300_0004, 32'h0000_FFFF, 32'h0, 1'b0, 2);
    requester(0, 1'b1, 32'h5300_0004, 32'h0000_FFFF);
    drain(20);

    // Single read from requester 1
    slave_rdata = 32'h0000_A5A5;
    expect_xfer(1, 1'b0, 32'h5300_0000, 32'h0, 32'h0000_A5A5, 1'b0, 2);
    requester(1, 1'b0, 32'h5300_0000, 32'h0);
    drain(20);

    // Both requesters held: grants alternate 0,1,0,1
    slave_rdata = 32'h0000_1234;
    expect_xfer(0, 1'b1, 32'h5300_0000, 32'h0000_0011, 32'h0, 1'b0, 2);
    expect_xfer(1, 1'b0, 32'h5300_0000, 32'h0, 32'h0000_1234, 1'b0, 2);
    expect_xfer(0, 1'b0, 32'h5300_0004, 32'h0, 32'h0000_1234, 1'b0, 2);
    expect_xfer(1, 1'b1, 32'h5300_0004, 32'h0000_0022, 32'h0, 1'b0, 2);
    fork
      begin
        requester(0, 1'b1, 32'h5300_0000, 32'h0000_0011);
        requester(0, 1'b0, 32'h5300_0004, 32'h0);
      end
      begin
        requester(1, 1'b0, 32'h5300_0000, 32'h0);
        requester(1, 1'b1, 32'h5300_0004, 32'h0000_0022);
      end
    join
    drain(40);

    // Three data-phase wait states
    stall_cfg = 3;
    expect_xfer(0, 1'b1, 32'h5300_0004, 32'h0000_00F0, 32'h0, 1'b0, 5);
    requester(0, 1'b1, 32'h5300_0004, 32'h0000_00F0);
    drain(30);
    stall_cfg = 0;

    // Slave stuck: timeout abort, RDATA must not pick up the stale bus value
    slave_rdata = 32'hDEAD_BEEF;
    stuck = 1'b1;
    expect_xfer(1, 1'b0, 32'h5300_0000, 32'h0, 32'h0, 1'b1, 17);
    requester(1, 1'b0, 32'h5300_0000, 32'h0);
    drain(40);
    stuck = 1'b0;
    slave_rdata = 32'h0000_5A5A;
    expect_xfer(0, 1'b0, 32'h5300_0000, 32'h0, 32'h0000_5A5A, 1'b0, 2);
    requester(0, 1'b0, 32'h5300_0000, 32'h0);
    drain(20);

    // Reset during a stalled write data phase
    stall_cfg = 10;
    expect_xfer(0, 1'b1, 32'h5300_0004, 32'h0000_CAFE, 32'h0, 1'b0, 0);
    requester(0, 1'b1, 32'h5300_0004, 32'h0000_CAFE);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    stall_cfg = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_done_after_rst", bus.DONE, 0);
    end
    slave_rdata = 32'h0000_0077;
    expect_xfer(0, 1'b0, 32'h5300_0000, 32'h0, 32'h0000_0077, 1'b0, 2);
    expect_xfer(1, 1'b0, 32'h5300_0004, 32'h0, 32'h0000_0077, 1'b0, 2);
    fork
      requester(0, 1'b0, 32'h5300_0000, 32'h0);
      requester(1, 1'b0, 32'h5300_0004, 32'h0);
    join
    drain(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
